ps2_player_input: RTL and testbench

//  PS/2 keyboard front end producing both players' control inputs for game_ctrl
//  (moves/fire/skill held levels, skill select, ready, game_reset pulse).

---
 rtl/ps2_keys_pkg.sv | 98 +++++++++
 rtl/ps2_rx.sv | 137 +++++++++++++
 rtl/ps2_player_input.sv | 124 ++++++++++++
 tb/tb_ps2_player_input.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// PS/2 set-2 scan codes, receiver state encoding and held-key indices.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
// Contents: SC_* scan codes, rx_state_t, KEY_* indices into the held vector, key_lookup().
package ps2_keys_pkg;

  // Prefix / control codes
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;

  // Player 1 keys (plain codes)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_E     = 8'h24;

  // Player 2 keys: arrows are E0-extended, keypad keys are plain
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_KP1   = 8'h69;
  localparam logic [7:0] SC_KP2   = 8'h72;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP5   = 8'h73;

  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Held-key vector layout
  localparam int KEY_NUM = 17;
  localparam int KEY_W   = 5;

  localparam logic [KEY_W-1:0] KEY_P1_UP    = 5'd0;
  localparam logic [KEY_W-1:0] KEY_P1_DOWN  = 5'd1;
  localparam logic [KEY_W-1:0] KEY_P1_LEFT  = 5'd2;
  localparam logic [KEY_W-1:0] KEY_P1_RIGHT = 5'd3;
  localparam logic [KEY_W-1:0] KEY_P1_FIRE  = 5'd4;
  localparam logic [KEY_W-1:0] KEY_P1_SKILL = 5'd5;
  localparam logic [KEY_W-1:0] KEY_P2_UP    = 5'd6;
  localparam logic [KEY_W-1:0] KEY_P2_DOWN  = 5'd7;
  localparam logic [KEY_W-1:0] KEY_P2_LEFT  = 5'd8;
  localparam logic [KEY_W-1:0] KEY_P2_RIGHT = 5'd9;
  localparam logic [KEY_W-1:0] KEY_P2_FIRE  = 5'd10;
  localparam logic [KEY_W-1:0] KEY_P2_SKILL = 5'd11;
  localparam logic [KEY_W-1:0] KEY_P1_CYC   = 5'd12;
  localparam logic [KEY_W-1:0] KEY_P1_RDY   = 5'd13;
  localparam logic [KEY_W-1:0] KEY_P2_CYC   = 5'd14;
  localparam logic [KEY_W-1:0] KEY_P2_RDY   = 5'd15;
  localparam logic [KEY_W-1:0] KEY_ESC      = 5'd16;
  localparam logic [KEY_W-1:0] KEY_NONE     = 5'd31;

  // Map {ext, code} to a held-vector index; KEY_NONE for anything we ignore.
  function automatic logic [KEY_W-1:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [KEY_W-1:0] idx;
    idx = KEY_NONE;
    if (ext) begin
      case (code)
        SC_UP:    idx = KEY_P2_UP;
        SC_DOWN:  idx = KEY_P2_DOWN;
        SC_LEFT:  idx = KEY_P2_LEFT;
        SC_RIGHT: idx = KEY_P2_RIGHT;
        default:  idx = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_W:    idx = KEY_P1_UP;
        SC_S:    idx = KEY_P1_DOWN;
        SC_A:    idx = KEY_P1_LEFT;
        SC_D:    idx = KEY_P1_RIGHT;
        SC_J:    idx = KEY_P1_FIRE;
        SC_K:    idx = KEY_P1_SKILL;
        SC_Q:    idx = KEY_P1_CYC;
        SC_E:    idx = KEY_P1_RDY;
        SC_KP1:  idx = KEY_P2_FIRE;
        SC_KP2:  idx = KEY_P2_SKILL;
        SC_KP4:  idx = KEY_P2_CYC;
        SC_KP5:  idx = KEY_P2_RDY;
        SC_ESC:  idx = KEY_ESC;
        SC_E1:   idx = KEY_NONE;  // pause prefix: deliberately no key
        default: idx = KEY_NONE;
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device->host frame receiver: synchronisers, ps2_clk glitch filter, frame FSM, timeout.
// Latency: code_valid pulses the cycle after the filtered stop-bit fall is sampled.
// Backpressure: none; PS/2 cannot be stalled, every accepted frame is strobed once.
// Ports: clk, rstn, ps2_clk, ps2_data in; code[7:0], code_valid, parity_err out.
// Config: PS2_PARITY_CHECK_EN enables odd-parity checking (parity_err strobes on a bad frame).
module ps2_rx
  import ps2_keys_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;

`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit;
  logic          par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Synchronisers and filter. Lines idle high, so reset to 1 to avoid a
  // spurious fall straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_MAX) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Filtered falling edge: the cycle the new low level is accepted.
  assign fall = clk_f & ~clk_s2 & (flt_cnt == FLT_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      to_cnt     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_err_q  <= 1'b0;
`endif
      // Timeout counts cycles since the last fall while a frame is open.
      if (state == RX_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;

      if (state != RX_IDLE && !fall && to_cnt == TO_MAX) begin
        state <= RX_IDLE;  // stalled keyboard: drop the partial frame silently
      end else if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_s2) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};  // LSB arrives first
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= dat_s2;
`endif
            state   <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (dat_s2) begin
`ifdef PS2_PARITY_CHECK_EN
              if (^{shreg, par_bit}) begin
                code       <= shreg;
                code_valid <= 1'b1;
              end else begin
                par_err_q  <= 1'b1;
              end
`else
              code       <= shreg;
              code_valid <= 1'b1;
`endif
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_player_input.sv
// PS/2 keyboard front end: set-2 decode, held-key levels for two players, skill/ready menu, reset pulse.
// Latency: held/menu outputs and game_reset update 2 cycles after the stop bit is sampled.
// Backpressure: none; decoded keys are applied immediately and cannot be held off.
// Ports: clk, rstn, ps2_clk, ps2_data, game_start in; p1_/p2_ up/down/left/right/fire/skill,
//        p1_/p2_skill_sel[1:0], p1_/p2_ready, game_reset out.
// Config: PS2_PARITY_CHECK_EN (in ps2_rx) drops bad-parity frames and clears the E0/F0 flags.
module ps2_player_input
  import ps2_keys_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       game_start,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p1_fire,
  output logic       p1_skill,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right,
  output logic       p2_fire,
  output logic       p2_skill,
  output logic [1:0] p1_skill_sel,
  output logic [1:0] p2_skill_sel,
  output logic       p1_ready,
  output logic       p2_ready,
  output logic       game_reset
);

  logic [7:0]         code;
  logic               code_valid;
  logic               parity_err;

  logic               ext, brk;
  logic [KEY_NUM-1:0] held;
  logic [KEY_W-1:0]   key_idx;
  logic [KEY_NUM-1:0] key_oh;
  logic [KEY_NUM-1:0] press;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .parity_err (parity_err)
  );

  // key_oh is one-hot on the key addressed by this code (zero for prefixes
  // and unmapped codes). press marks a genuine new press: a make of a key not
  // already held, so typematic repeats never retrigger menu actions.
  always_comb begin
    key_idx = key_lookup(ext, code);
    key_oh  = '0;
    if (code_valid && key_idx != KEY_NONE) key_oh = KEY_NUM'(1) << key_idx;
    press   = key_oh & ~held & {KEY_NUM{~brk}};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext          <= 1'b0;
      brk          <= 1'b0;
      held         <= '0;
      p1_skill_sel <= 2'd0;
      p2_skill_sel <= 2'd0;
      p1_ready     <= 1'b0;
      p2_ready     <= 1'b0;
      game_reset   <= 1'b0;
    end else begin
      if (code_valid) begin
        if (code == SC_E0) begin
          ext <= 1'b1;
        end else if (code == SC_F0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      if (parity_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end

      held <= brk ? (held & ~key_oh) : (held | key_oh);

      game_reset <= press[KEY_ESC];
      if (press[KEY_ESC]) begin
        p1_ready <= 1'b0;
        p2_ready <= 1'b0;
      end else if (!game_start) begin
        if (press[KEY_P1_RDY]) p1_ready <= ~p1_ready;
        if (press[KEY_P2_RDY]) p2_ready <= ~p2_ready;
        if (press[KEY_P1_CYC] && !p1_ready) p1_skill_sel <= p1_skill_sel + 2'd1;
        if (press[KEY_P2_CYC] && !p2_ready) p2_skill_sel <= p2_skill_sel + 2'd1;
      end
    end
  end

  assign p1_up    = held[KEY_P1_UP];
  assign p1_down  = held[KEY_P1_DOWN];
  assign p1_left  = held[KEY_P1_LEFT];
  assign p1_right = held[KEY_P1_RIGHT];
  assign p1_fire  = held[KEY_P1_FIRE];
  assign p1_skill = held[KEY_P1_SKILL];
  assign p2_up    = held[KEY_P2_UP];
  assign p2_down  = held[KEY_P2_DOWN];
  assign p2_left  = held[KEY_P2_LEFT];
  assign p2_right = held[KEY_P2_RIGHT];
  assign p2_fire  = held[KEY_P2_FIRE];
  assign p2_skill = held[KEY_P2_SKILL];

endmodule

// File: tb/tb_ps2_player_input.sv
// Bench for ps2_player_input: PS/2 frames driven bit by bit, expected output snapshots
// queued per frame and popped once the frame has been absorbed.
`timescale 1ns/1ps
module tb_ps2_player_input;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HP          = 16;   // PS/2 half-bit period in clk cycles

  // Bit positions inside obs_t.p1 / obs_t.p2
  localparam int UP = 5, DN = 4, LT = 3, RT = 2, FI = 1, SK = 0;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic game_start = 1'b0;
  logic p1_up, p1_down, p1_left, p1_right, p1_fire, p1_skill;
  logic p2_up, p2_down, p2_left, p2_right, p2_fire, p2_skill;
  logic [1:0] p1_skill_sel, p2_skill_sel;
  logic p1_ready, p2_ready, game_reset;

  ps2_player_input #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .game_start   (game_start),
    .p1_up        (p1_up),
    .p1_down      (p1_down),
    .p1_left      (p1_left),
    .p1_right     (p1_right),
    .p1_fire      (p1_fire),
    .p1_skill     (p1_skill),
    .p2_up        (p2_up),
    .p2_down      (p2_down),
    .p2_left      (p2_left),
    .p2_right     (p2_right),
    .p2_fire      (p2_fire),
    .p2_skill     (p2_skill),
    .p1_skill_sel (p1_skill_sel),
    .p2_skill_sel (p2_skill_sel),
    .p1_ready     (p1_ready),
    .p2_ready     (p2_ready),
    .game_reset   (game_reset)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] p1;
    logic [5:0] p2;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       r1;
    logic       r2;
  } obs_t;

  obs_t  exp_o;
  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    fall_cyc = 0;
  int    rise_cyc = -1000;
  int    gr_pulses = 0;
  int    gr_cycles = 0;
  logic  up_q = 1'b0;
  logic  gr_q = 1'b0;
  string phase = "rst";

  function automatic obs_t observe();
    obs_t o;
    o.p1 = {p1_up, p1_down, p1_left, p1_right, p1_fire, p1_skill};
    o.p2 = {p2_up, p2_down, p2_left, p2_right, p2_fire, p2_skill};
    o.s1 = p1_skill_sel;
    o.s2 = p2_skill_sel;
    o.r1 = p1_ready;
    o.r2 = p2_ready;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors sampled on the falling clk edge
  always @(negedge clk) begin
    if (p1_up && !up_q) rise_cyc = cyc;
    up_q = p1_up;
    if (game_reset) gr_cycles++;
    if (game_reset && !gr_q) gr_pulses++;
    gr_q = game_reset;
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HP) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HP) @(negedge clk);
    ps2_clk  = 1'b1;
  endtask

  // Push the expected snapshot, drive (part of) a frame, then pop and compare.
  task automatic send(input logic [7:0] c, input logic bad_par = 1'b0,
                      input logic stop_b = 1'b1, input int nbits = 11);
    logic [10:0] f;
    obs_t e;
    exp_q.push_back(exp_o);
    f = {stop_b, (~^c) ^ bad_par, c, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("%s code %02h", phase, c), 32'(observe()), 32'(e));
  endtask

  logic [7:0] p1_codes [5];
  logic [7:0] p2_codes [4];
  logic       p2_ext   [4];
  int         p2_bits  [4];
  int         g0, c0;

  initial begin
    p1_codes = '{8'h1B, 8'h1C, 8'h23, 8'h3B, 8'h42};  // S A D J K -> down..skill
    p2_codes = '{8'h6B, 8'h74, 8'h69, 8'h72};
    p2_ext   = '{1'b1, 1'b1, 1'b0, 1'b0};
    p2_bits  = '{LT, RT, FI, SK};
    exp_o = '0;

    repeat (5) @(negedge clk);
    chk("reset outputs", 32'(observe()), 32'(0));
    chk("reset game_reset", 32'(game_reset), 32'(0));
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // T1: W make/break, with latency from stop-bit fall:
    // 2 sync flops + FILTER_LEN filter cycles + 1 code_valid->held register.
    phase = "t1";
    exp_o.p1[UP] = 1'b1; send(8'h1D);
    chk("t1 latency", 32'(rise_cyc - fall_cyc), 32'(2 + FILTER_LEN + 1));
    send(8'hF0);
    exp_o.p1[UP] = 1'b0; send(8'h1D);
    for (int i = 0; i < 5; i++) begin
      exp_o.p1[DN - i] = 1'b1; send(p1_codes[i]);
    end
    for (int i = 0; i < 5; i++) begin
      send(8'hF0);
      exp_o.p1[DN - i] = 1'b0; send(p1_codes[i]);
    end

    // T2: extended arrows vs keypad; KP8 and E1 have no effect
    phase = "t2";
    send(8'hE0);
    exp_o.p2[UP] = 1'b1; send(8'h75);
    send(8'hE0); send(8'hF0);
    exp_o.p2[UP] = 1'b0; send(8'h75);
    send(8'h75);                              // KP8: unmapped
    send(8'hE0); send(8'hE1); send(8'h75);    // E1 clears ext -> KP8 again
    send(8'hE0);
    exp_o.p2[DN] = 1'b1; send(8'h72);         // Down
    exp_o.p2[SK] = 1'b1; send(8'h72);         // KP2, distinct key
    send(8'hF0);
    exp_o.p2[SK] = 1'b0; send(8'h72);
    send(8'hE0); send(8'hF0);
    exp_o.p2[DN] = 1'b0; send(8'h72);
    for (int i = 0; i < 4; i++) begin
      if (p2_ext[i]) send(8'hE0);
      exp_o.p2[p2_bits[i]] = 1'b1; send(p2_codes[i]);
      if (p2_ext[i]) send(8'hE0);
      send(8'hF0);
      exp_o.p2[p2_bits[i]] = 1'b0; send(p2_codes[i]);
    end

    // T3: Q cycles skill select; typematic repeats count once
    phase = "t3";
    for (int i = 1; i <= 5; i++) begin
      exp_o.s1 = 2'(i); send(8'h15);
      send(8'hF0); send(8'h15);
    end
    exp_o.s1 = 2'd2;
    send(8'h15); send(8'h15); send(8'h15);
    send(8'hF0); send(8'h15);

    // T4: ready blocks cycling; game_start freezes menu
    phase = "t4";
    exp_o.r1 = 1'b1; send(8'h24);
    send(8'hF0); send(8'h24);
    send(8'h15); send(8'hF0); send(8'h15);    // sel stays 2
    game_start = 1'b1;
    send(8'h24); send(8'hF0); send(8'h24);    // ready stays 1
    send(8'h73); send(8'hF0); send(8'h73);    // KP5 frozen
    send(8'h6B); send(8'hF0); send(8'h6B);    // KP4 frozen
    game_start = 1'b0;
    exp_o.s2 = 2'd1; send(8'h6B); send(8'hF0); send(8'h6B);
    exp_o.r2 = 1'b1; send(8'h73); send(8'hF0); send(8'h73);

    // T5: Esc pulse clears both ready, keeps selections
    phase = "t5";
    g0 = gr_pulses; c0 = gr_cycles;
    exp_o.r1 = 1'b0; exp_o.r2 = 1'b0; send(8'h76);
    chk("t5 reset pulses", 32'(gr_pulses), 32'(g0 + 1));
    chk("t5 reset width", 32'(gr_cycles), 32'(c0 + 1));
    send(8'h76);                              // repeat: no new pulse
    send(8'hF0); send(8'h76);
    chk("t5 repeat pulses", 32'(gr_pulses), 32'(g0 + 1));

    // T6: dropped frames, then recovery
    phase = "t6";
    send(8'h1D, 1'b0, 1'b0);                  // stop bit 0
    send(8'h1D, 1'b0, 1'b1, 4);               // partial frame
    repeat (TIMEOUT_CYC + 1000) @(negedge clk);
    exp_o.p1[UP] = 1'b1; send(8'h1D);
    send(8'hF0);
    exp_o.p1[UP] = 1'b0; send(8'h1D);
`ifdef PS2_PARITY_CHECK_EN
    send(8'h1D, 1'b1);                        // bad parity: dropped
    send(8'hF0);
    send(8'h1C, 1'b1);                        // bad parity also clears brk
    exp_o.p1[UP] = 1'b1; send(8'h1D);
    send(8'hF0);
    exp_o.p1[UP] = 1'b0; send(8'h1D);
`else
    exp_o.p1[UP] = 1'b1; send(8'h1D, 1'b1);   // parity ignored
    send(8'hF0);
    exp_o.p1[UP] = 1'b0; send(8'h1D);
`endif

    // T7: reset mid-frame, then a clean frame
    phase = "t7";
    send(8'h1D, 1'b0, 1'b1, 5);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    exp_o = '0;
    chk("t7 after reset", 32'(observe()), 32'(exp_o));
    exp_o.p1[UP] = 1'b1; send(8'h1D);
    send(8'hF0);
    exp_o.p1[UP] = 1'b0; send(8'h1D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
